// File: rtl/fpadd_rr_arbiter.sv
// Two requesters share one combinational FP16 adder. Grants are round-robin or
// fixed-priority; the adder sits between an operand stage and per-requester result registers.

module FPADD (
  input  logic [15:0] opA_i,
  input  logic [15:0] opB_i,
  output logic [15:0] ADD_o
);
  logic        swap;
  logic [15:0] a, b;
  logic [4:0]  ea, eb, d;
  logic [13:0] ma, mb, mb_sh;
  logic [14:0] s;
  logic [5:0]  e;

  // Truncating adder: align with three guard bits, add or subtract magnitudes, renormalise.
  always_comb begin
    swap  = opB_i[14:0] > opA_i[14:0];
    a     = swap ? opB_i : opA_i;
    b     = swap ? opA_i : opB_i;
    ea    = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb    = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma    = {(a[14:10] != 5'd0), a[9:0], 3'b000};
    mb    = {(b[14:10] != 5'd0), b[9:0], 3'b000};
    d     = ea - eb;
    mb_sh = (d > 5'd13) ? 14'd0 : (mb >> d);
    s     = (a[15] == b[15]) ? ({1'b0, ma} + {1'b0, mb_sh}) : ({1'b0, ma} - {1'b0, mb_sh});
    e     = {1'b0, ea};
    if (s[14]) begin
      s = s >> 1;
      e = e + 6'd1;
    end
    for (int i = 0; i < 13; i++) begin
      if (!s[13] && (e > 6'd1)) begin
        s = s << 1;
        e = e - 6'd1;
      end
    end
    if (!s[13]) e = 6'd0;
    if (a[14:10] == 5'h1f)  ADD_o = a;
    else if (e >= 6'd31)    ADD_o = {a[15], 5'h1f, 10'h000};
    else if (s == 15'd0)    ADD_o = 16'h0000;
    else                    ADD_o = {a[15], e[4:0], s[12:3]};
  end
endmodule

module fpadd_rr_lane (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gnt,
  input  logic        cap,
  input  logic [15:0] sum,
  input  logic        rsp_ready,
  output logic        idle,
  output logic        rsp_valid,
  output logic [15:0] rsp_data
);
  typedef enum logic [1:0] {IDLE, INFLIGHT, RESULT} st_t;
  st_t st, st_nx;

  always_ff @(posedge clk_i) begin
    if (rst_i) st <= IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:     if (gnt) st_nx = INFLIGHT;
      INFLIGHT: st_nx = RESULT;
      RESULT:   if (rsp_ready) st_nx = IDLE;
      default:  st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)    rsp_data <= 16'h0000;
    else if (cap) rsp_data <= sum;
  end

  assign idle      = (st == IDLE);
  assign rsp_valid = (st == RESULT);
endmodule

module fpadd_rr_arbiter #(
  parameter int PRIO_FIXED = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [15:0]      req0_opA_i,
  input  logic [15:0]      req0_opB_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [15:0]      req1_opA_i,
  input  logic [15:0]      req1_opB_i,
  output logic             rsp0_valid_o,
  output logic [15:0]      rsp0_data_o,
  input  logic             rsp0_ready_i,
  output logic             rsp1_valid_o,
  output logic [15:0]      rsp1_data_o,
  input  logic             rsp1_ready_i,
  output logic [CNT_W-1:0] op_cnt_o
);
  logic [1:0]       vld, idle, elig, gnt, rsp_v, rsp_rdy, rsp_hs;
  logic [1:0][15:0] opa, opb, rdata;
  logic             win, last, stage_v, owner_q;
  logic [15:0]      opa_q, opb_q, add_sum;
  logic [CNT_W-1:0] cnt_q;

  assign vld     = {req1_valid_i, req0_valid_i};
  assign opa     = {req1_opA_i, req0_opA_i};
  assign opb     = {req1_opB_i, req0_opB_i};
  assign rsp_rdy = {rsp1_ready_i, rsp0_ready_i};
  assign elig    = vld & idle & {2{~rst_i}};
  assign rsp_hs  = rsp_v & rsp_rdy;

  // On a tie the requester not served last wins, unless priority is fixed to 0.
  always_comb begin
    win = 1'b0;
    if (elig == 2'b11) win = (PRIO_FIXED != 0) ? 1'b0 : ~last;
    else               win = elig[1] & ~elig[0];
  end

  assign gnt = {elig[1] & win, elig[0] & ~win};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last    <= 1'b1;
      stage_v <= 1'b0;
      owner_q <= 1'b0;
      opa_q   <= 16'h0000;
      opb_q   <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      stage_v <= |gnt;
      if (|gnt) begin
        last    <= win;
        owner_q <= win;
        opa_q   <= opa[win];
        opb_q   <= opb[win];
      end
      cnt_q <= cnt_q + CNT_W'(rsp_hs[0]) + CNT_W'(rsp_hs[1]);
    end
  end

  FPADD u_add (.opA_i(opa_q), .opB_i(opb_q), .ADD_o(add_sum));

  for (genvar r = 0; r < 2; r++) begin : g_lane
    fpadd_rr_lane u_lane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .gnt       (gnt[r]),
      .cap       (stage_v && (owner_q == 1'(r))),
      .sum       (add_sum),
      .rsp_ready (rsp_rdy[r]),
      .idle      (idle[r]),
      .rsp_valid (rsp_v[r]),
      .rsp_data  (rdata[r])
    );
  end

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign rsp0_valid_o = rsp_v[0];
  assign rsp1_valid_o = rsp_v[1];
  assign rsp0_data_o  = rdata[0];
  assign rsp1_data_o  = rdata[1];
  assign op_cnt_o     = cnt_q;
endmodule

// File: tb/tb_fpadd_rr_arbiter.sv
// Bench for fpadd_rr_arbiter: round-robin, fixed-priority and 3-bit-counter instances share
// stimulus and are checked against a timestamp-based transaction model.
module tb_fpadd_rr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic [15:0] a0 = 16'h0, b0 = 16'h0, a1 = 16'h0, b1 = 16'h0;

  logic [1:0]  g_rdy [2];
  logic [1:0]  g_rv  [2];
  logic [15:0] g_dat [2][2];
  logic [15:0] g_cnt [2];
  logic [1:0]  w3_rdy, w3_rv;
  logic [15:0] w3_d0, w3_d1;
  logic [2:0]  w3_cnt;
  logic [15:0] ref0, ref1;

  fpadd_rr_arbiter #(.PRIO_FIXED(0), .CNT_W(16)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(g_rdy[0][0]), .req0_opA_i(a0), .req0_opB_i(b0),
    .req1_valid_i(v1), .req1_ready_o(g_rdy[0][1]), .req1_opA_i(a1), .req1_opB_i(b1),
    .rsp0_valid_o(g_rv[0][0]), .rsp0_data_o(g_dat[0][0]), .rsp0_ready_i(rr0),
    .rsp1_valid_o(g_rv[0][1]), .rsp1_data_o(g_dat[0][1]), .rsp1_ready_i(rr1),
    .op_cnt_o(g_cnt[0]));

  fpadd_rr_arbiter #(.PRIO_FIXED(1), .CNT_W(16)) dut_fx (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(g_rdy[1][0]), .req0_opA_i(a0), .req0_opB_i(b0),
    .req1_valid_i(v1), .req1_ready_o(g_rdy[1][1]), .req1_opA_i(a1), .req1_opB_i(b1),
    .rsp0_valid_o(g_rv[1][0]), .rsp0_data_o(g_dat[1][0]), .rsp0_ready_i(rr0),
    .rsp1_valid_o(g_rv[1][1]), .rsp1_data_o(g_dat[1][1]), .rsp1_ready_i(rr1),
    .op_cnt_o(g_cnt[1]));

  fpadd_rr_arbiter #(.PRIO_FIXED(0), .CNT_W(3)) dut_w3 (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(w3_rdy[0]), .req0_opA_i(a0), .req0_opB_i(b0),
    .req1_valid_i(v1), .req1_ready_o(w3_rdy[1]), .req1_opA_i(a1), .req1_opB_i(b1),
    .rsp0_valid_o(w3_rv[0]), .rsp0_data_o(w3_d0), .rsp0_ready_i(rr0),
    .rsp1_valid_o(w3_rv[1]), .rsp1_data_o(w3_d1), .rsp1_ready_i(rr1),
    .op_cnt_o(w3_cnt));

  // Standalone adders give the reference sum for whatever operands are presented.
  FPADD u_ref0 (.opA_i(a0), .opB_i(b0), .ADD_o(ref0));
  FPADD u_ref1 (.opA_i(a1), .opB_i(b1), .ADD_o(ref1));

  int checks = 0, errors = 0;
  int cyc = 0;
  int acc [2][2] = '{'{-1, -1}, '{-1, -1}};   // cycle of accepted op, -1 when none outstanding
  logic [15:0] edata [2][2] = '{'{16'h0, 16'h0}, '{16'h0, 16'h0}};
  int last_w [2] = '{1, 1};
  int mcnt [2] = '{0, 0};

  function automatic logic rdy(int r);
    return (r == 1) ? rr1 : rr0;
  endfunction

  function automatic logic rv(int m, int r);
    return (acc[m][r] >= 0) && (cyc >= acc[m][r] + 2);
  endfunction

  function automatic int winner(int m);
    logic e0, e1;
    if (rst) return -1;
    e0 = v0 && (acc[m][0] < 0);
    e1 = v1 && (acc[m][1] < 0);
    if (e0 && e1) return (m == 1) ? 0 : ((last_w[m] == 0) ? 1 : 0);
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_rdy(int m);
    int w;
    w = winner(m);
    if (w == 0) return 2'b01;
    if (w == 1) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        acc[m][0] <= -1;
        acc[m][1] <= -1;
        last_w[m] <= 1;
        mcnt[m]   <= 0;
      end else begin
        mcnt[m] <= mcnt[m] + int'(rv(m, 0) && rr0) + int'(rv(m, 1) && rr1);
        for (int r = 0; r < 2; r++) begin
          if (winner(m) == r) begin
            acc[m][r]   <= cyc;
            edata[m][r] <= (r == 0) ? ref0 : ref1;
            last_w[m]   <= r;
          end else if (rv(m, r) && rdy(r)) begin
            acc[m][r] <= -1;
          end
        end
      end
    end
    cyc <= cyc + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (g_rdy[0] !== 2'b00 || g_rdy[1] !== 2'b00 || w3_rdy !== 2'b00)
        $display("FAIL reset_ready: got %b %b %b required 00", g_rdy[0], g_rdy[1], w3_rdy);
    end
    @(negedge clk);
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (g_rv[m] !== 2'b00 || g_dat[m][0] !== 16'h0 || g_dat[m][1] !== 16'h0 || g_cnt[m] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got rv=%b d0=%h d1=%h cnt=%0d required all zero",
                 m, g_rv[m], g_dat[m][0], g_dat[m][1], g_cnt[m]);
      end
    end
    checks++;
    if (w3_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt3: got %0d required 0", w3_cnt); end
  endtask

  task automatic test_single_op();
    do_reset();
    @(negedge clk);
    v0 = 1'b1; a0 = 16'h3E00; b0 = 16'h3C00; rr0 = 1'b1; #1;
    checks++;
    if (g_rdy[0][0] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", g_rdy[0][0]); end
    @(negedge clk);
    v0 = 1'b0; a0 = 16'(($urandom)); b0 = 16'(($urandom)); #1;
    checks++;
    if (g_rv[0][0] !== 1'b0) begin errors++; $display("FAIL single_early: got %b required 0", g_rv[0][0]); end
    @(negedge clk); #1;
    checks++;
    if (g_rv[0][0] !== 1'b1 || g_dat[0][0] !== 16'h4100) begin
      errors++;
      $display("FAIL single_rsp: got v=%b d=%h required v=1 d=4100", g_rv[0][0], g_dat[0][0]);
    end
    @(negedge clk); #1;
    checks++;
    if (g_cnt[0] !== 16'd1 || g_rv[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL single_cnt: got cnt=%0d v=%b required cnt=1 v=0", g_cnt[0], g_rv[0][0]);
    end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; a0 = 16'h4100; b0 = 16'hBE00; a1 = 16'h3C00; b1 = 16'h3C00;
    rr0 = 1'b1; rr1 = 1'b1; #1;
    checks++;
    if (g_rdy[0] !== 2'b01 || g_rdy[1] !== 2'b01) begin
      errors++; $display("FAIL tie_first: got rr=%b fx=%b required 01", g_rdy[0], g_rdy[1]);
    end
    @(negedge clk);
    v0 = 1'b0; a0 = 16'(($urandom)); #1;
    checks++;
    if (g_rdy[0] !== 2'b10 || g_rdy[1] !== 2'b10) begin
      errors++; $display("FAIL tie_second: got rr=%b fx=%b required 10", g_rdy[0], g_rdy[1]);
    end
    @(negedge clk);
    v1 = 1'b0; a1 = 16'(($urandom)); #1;
    checks++;
    if (g_rv[0][0] !== 1'b1 || g_dat[0][0] !== 16'h3C00) begin
      errors++; $display("FAIL tie_rsp0: got v=%b d=%h required v=1 d=3c00", g_rv[0][0], g_dat[0][0]);
    end
    @(negedge clk); #1;
    checks++;
    if (g_rv[0][1] !== 1'b1 || g_dat[0][1] !== 16'h4000) begin
      errors++; $display("FAIL tie_rsp1: got v=%b d=%h required v=1 d=4000", g_rv[0][1], g_dat[0][1]);
    end
  endtask

  task automatic test_fairness();
    int prev = -1;
    int g;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      v0 = 1'b1; v1 = 1'b1;
      rr0 = ($urandom_range(3) != 0); rr1 = ($urandom_range(3) != 0);
      a0 = 16'(($urandom)); b0 = 16'(($urandom)); a1 = 16'(($urandom)); b1 = 16'(($urandom)); #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (g_rdy[m] !== exp_rdy(m)) begin
          errors++; $display("FAIL fair_grant[%0d] cyc %0d: got %b required %b", m, cyc, g_rdy[m], exp_rdy(m));
        end
      end
      g = g_rdy[0][0] ? 0 : (g_rdy[0][1] ? 1 : -1);
      if (g >= 0) begin
        checks++;
        if (g == prev && acc[0][1-g] < 0) begin
          errors++; $display("FAIL fair_repeat: got grant %0d twice required alternation", g);
        end
        prev = g;
      end
    end
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [15:0] hold;
    int hs = 0;
    logic seen = 1'b0;
    do_reset();
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; rr0 = 1'b0; rr1 = 1'b1;
    a0 = 16'(($urandom)); b0 = 16'(($urandom)); a1 = 16'(($urandom)); b1 = 16'(($urandom));
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      a1 = 16'(($urandom)); b1 = 16'(($urandom)); #1;
      seen = g_rv[0][0];
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_wait: got no rsp0_valid required within 10 cycles"); end
    hold = g_dat[0][0];
    checks++;
    if (hold !== edata[0][0]) begin errors++; $display("FAIL bp_data: got %h required %h", hold, edata[0][0]); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (g_dat[0][0] !== hold || g_rdy[0][0] !== 1'b0 || g_rv[0][0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: got d=%h rdy=%b v=%b required d=%h rdy=0 v=1", g_dat[0][0], g_rdy[0][0], g_rv[0][0], hold);
      end
      if (g_rv[0][1] && rr1) hs++;
      @(negedge clk);
      a1 = 16'(($urandom)); b1 = 16'(($urandom)); #1;
    end
    checks++;
    if (hs != 3) begin errors++; $display("FAIL bp_other: got %0d req1 completions required 3", hs); end
    rr0 = 1'b1; #1;
    checks++;
    if (g_rdy[0][0] !== 1'b0) begin errors++; $display("FAIL bp_same_cycle: got rdy0=%b required 0", g_rdy[0][0]); end
    @(negedge clk); #1;
    checks++;
    if (g_rdy[0] !== exp_rdy(0) || g_rv[0][0] !== 1'b0) begin
      errors++; $display("FAIL bp_after: got rdy=%b v0=%b required rdy=%b v0=0", g_rdy[0], g_rv[0][0], exp_rdy(0));
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    v0 = 1'b1; a0 = 16'(($urandom)); b0 = 16'(($urandom)); rr0 = 1'b1; #1;
    checks++;
    if (g_rdy[0][0] !== 1'b1) begin errors++; $display("FAIL rmid_accept: got %b required 1", g_rdy[0][0]); end
    @(negedge clk);
    v0 = 1'b1; rst = 1'b1; #1;
    checks++;
    if (g_rdy[0] !== 2'b00) begin errors++; $display("FAIL rmid_rst_ready: got %b required 00", g_rdy[0]); end
    @(negedge clk);
    rst = 1'b0; v0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (g_rv[0][0] !== 1'b0 || g_cnt[0] !== 16'd0) begin
        errors++; $display("FAIL rmid_discard: got v=%b cnt=%0d required v=0 cnt=0", g_rv[0][0], g_cnt[0]);
      end
      @(negedge clk);
    end
    v0 = 1'b1; v1 = 1'b1; #1;
    checks++;
    if (g_rdy[0] !== 2'b01) begin errors++; $display("FAIL rmid_tie: got %b required 01", g_rdy[0]); end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cnt_wrap();
    logic [15:0] want;
    do_reset();
    rr0 = 1'b1; rr1 = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      v0 = 1'b1;
      a0 = (n == 8) ? 16'h7BFF : 16'(($urandom_range(16'h7BFF)));
      b0 = (n == 8) ? 16'h7BFF : 16'(($urandom_range(16'h7BFF)));
      #1;
      want = ref0;
      checks++;
      if (g_rdy[0][0] !== 1'b1) begin errors++; $display("FAIL wrap_accept %0d: got %b required 1", n, g_rdy[0][0]); end
      @(negedge clk);
      v0 = 1'b0; a0 = 16'(($urandom)); b0 = 16'(($urandom));
      @(negedge clk); #1;
      checks++;
      if (g_rv[0][0] !== 1'b1 || g_dat[0][0] !== want) begin
        errors++; $display("FAIL wrap_data %0d: got v=%b d=%h required v=1 d=%h", n, g_rv[0][0], g_dat[0][0], want);
      end
      @(negedge clk); #1;
      checks++;
      if (w3_cnt !== 3'(n % 8) || g_cnt[0] !== 16'(n)) begin
        errors++; $display("FAIL wrap_cnt %0d: got cnt3=%0d cnt16=%0d required %0d %0d", n, w3_cnt, g_cnt[0], n % 8, n);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = ($urandom_range(99) == 0);
      v0 = $urandom_range(1); v1 = $urandom_range(1);
      rr0 = ($urandom_range(3) != 0); rr1 = ($urandom_range(3) != 0);
      a0 = 16'(($urandom)); b0 = 16'(($urandom)); a1 = 16'(($urandom)); b1 = 16'(($urandom)); #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (g_rdy[m] !== exp_rdy(m) || g_rv[m] !== {rv(m, 1), rv(m, 0)} || g_cnt[m] !== 16'(mcnt[m])) begin
          errors++;
          $display("FAIL rand_ctl[%0d] cyc %0d: got rdy=%b rv=%b cnt=%0d required rdy=%b rv=%b cnt=%0d",
                   m, cyc, g_rdy[m], g_rv[m], g_cnt[m], exp_rdy(m), {rv(m, 1), rv(m, 0)}, mcnt[m]);
        end
        for (int r = 0; r < 2; r++) begin
          if (rv(m, r)) begin
            checks++;
            if (g_dat[m][r] !== edata[m][r]) begin
              errors++; $display("FAIL rand_data[%0d][%0d]: got %h required %h", m, r, g_dat[m][r], edata[m][r]);
            end
          end
        end
      end
      checks++;
      if (w3_rdy !== exp_rdy(0) || w3_rv !== {rv(0, 1), rv(0, 0)} || w3_cnt !== 3'(mcnt[0]) ||
          (rv(0, 0) && w3_d0 !== edata[0][0]) || (rv(0, 1) && w3_d1 !== edata[0][1])) begin
        errors++;
        $display("FAIL rand_w3 cyc %0d: got rdy=%b rv=%b cnt=%0d required rdy=%b rv=%b cnt=%0d",
                 cyc, w3_rdy, w3_rv, w3_cnt, exp_rdy(0), {rv(0, 1), rv(0, 0)}, mcnt[0] % 8);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_tie();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpadd_rr_arbiter.md
# fpadd_rr_arbiter

Shares a single FP16 adder (`FPADD`, combinational, `opA_i`/`opB_i` -> `ADD_o`) between two requesters. Each requester uses a valid/ready request port and a valid/ready response port. Grants are round-robin or fixed-priority. Operands are registered before the adder and sums are held in per-requester result registers, so the adder's combinational path sits between two flop stages.

## Interface

**Parameters**
- `PRIO_FIXED`, default 0: 0 = round-robin; 1 = requester 0 always wins ties.
- `CNT_W`, default 16: width of the completed-operation counter.

**Ports**
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req0_valid_i` / `req1_valid_i`  in  1  request valid.
- `req0_ready_o` / `req1_ready_o`  out  1  request accepted this cycle.
- `req0_opA_i`, `req0_opB_i` / `req1_opA_i`, `req1_opB_i`  in  16  FP16 operands.
- `rsp0_valid_o` / `rsp1_valid_o`  out  1  result available.
- `rsp0_data_o` / `rsp1_data_o`  out  16  FP16 sum.
- `rsp0_ready_i` / `rsp1_ready_i`  in  1  requester consumes result.
- `op_cnt_o`  out  `CNT_W`  count of completed response handshakes; wraps.

## Operation

**Per-requester FSM** (r = 0, 1), with states IDLE, INFLIGHT, RESULT:
- IDLE -> INFLIGHT on a request handshake (`reqr_valid_i & reqr_ready_o`).
- INFLIGHT -> RESULT unconditionally one cycle later. At that edge, `ADD_o` is captured into `rspr_data_o`.
- RESULT -> IDLE on a response handshake (`rspr_valid_o & rspr_ready_i`).
- `rspr_valid_o` = (state == RESULT).

**Arbitration**
- A requester is eligible when its state is IDLE and its `reqr_valid_i` = 1.
- `reqr_ready_o` = eligible & granted. It is combinational from registered state and both `req*_valid_i`. It never depends on `rsp*_ready_i`.
- With one eligible requester, that requester is granted.
- With both eligible and `PRIO_FIXED`=0, the requester not granted last is granted.
- With both eligible and `PRIO_FIXED`=1, requester 0 is granted.
- The round-robin pointer `last` updates only on a grant. Reset value is `last`=1, so requester 0 wins the first tie.
- At most one grant per cycle. At most one operation in flight per requester.

**Operand stage**
- On a grant: `opA_q`/`opB_q` are loaded with the winner's operands, and `owner_q` is loaded with the winner index.
- `stage_v` = 1 for exactly the cycle after a grant.
- `FPADD` is driven from `opA_q`/`opB_q`. Its output is written to the result register selected by `owner_q` when `stage_v` = 1.

**Arithmetic**
- Results are bit-exact to `FPADD` for the same operands.
- This block does no rounding, special-case handling or exception flagging.

**Counter**
- `op_cnt_o` increments by 1 per response handshake.
- If both response handshakes occur in the same cycle, it increments by 2.
- It wraps modulo 2^`CNT_W`.

## Timing

- **Reset:** all FSMs go to IDLE, `stage_v`=0, `last`=1, `op_cnt_o`=0. `rsp*_data_o`=0 and `rsp*_valid_o`=0. `req*_ready_o` is 0 during every cycle in which `rst_i`=1.
- **Reset mid-operation:** in-flight operations and unconsumed results are discarded. No response is produced for them.
- **Latency:** request handshake at cycle T -> `rspr_valid_o`=1 from cycle T+2. Data is stable until the response handshake.
- **Per-requester throughput:**
  - Response handshake at cycle C -> FSM is IDLE at C+1 -> the earliest next request handshake is at C+1.
  - With `rspr_ready_i` held at 1, one operation completes every 3 cycles.
- **Alternating requesters:** a grant in consecutive cycles is allowed, because `stage_v`/`owner_q` pipeline one operation per cycle. Aggregate rate is up to 2 operations per 3 cycles.
- **Backpressure:** while `rspr_ready_i`=0 in RESULT, `rspr_data_o` holds and `reqr_ready_o`=0. The other requester proceeds unaffected.
- **Simultaneous events:** a response handshake for r and a request valid from r in the same cycle are handled as follows:
  - The request is not accepted that cycle, because the state is still RESULT.
  - The request is accepted at the next cycle if still valid.
- **Operand changes:** operand inputs are sampled only at the handshake edge. Changes after the handshake have no effect.

## Test plan

1. **Single op.** After reset, req0 = 0x3E00 + 0x3C00 (1.5 + 1.0) with `rsp0_ready_i`=1.
   - `req0_ready_o`=1 at T; `rsp0_valid_o`=1 at T+2 with `rsp0_data_o`=0x4100.
   - `op_cnt_o`=1 at T+3.
2. **Tie after reset, round-robin.** Both valid at T: req0 = 0x4100 + 0xBE00, req1 = 0x3C00 + 0x3C00.
   - req0 granted at T; `rsp0_data_o`=0x3C00 at T+2.
   - req1 granted at T+1; `rsp1_data_o`=0x4000 at T+3.
3. **Round-robin fairness.** Both valid continuously with responses always ready, `PRIO_FIXED`=0.
   - Grants alternate 0,1,0,1. Neither requester is granted twice in a row while the other is eligible.
   - Repeat with `PRIO_FIXED`=1: requester 0 wins every tie.
4. **Backpressure.** Hold `rsp0_ready_i`=0 for 10 cycles after `rsp0_valid_o` rises.
   - `rsp0_data_o` stays constant and `req0_ready_o`=0 throughout.
   - req1 completes 3 operations in that window.
5. **Reset mid-operation.** Assert `rst_i` one cycle after a req0 handshake.
   - No `rsp0_valid_o` appears, `op_cnt_o`=0, and the next tie grants req0.
6. **Counter wrap and overflow data.** Use `CNT_W`=3 with 9 completed operations.
   - `op_cnt_o` reads 7 then 0 then 1.
   - The operation 0x7BFF + 0x7BFF returns exactly the standalone `FPADD` output for those operands.
